// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package riscv_fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [XLEN-1:0] EBREAK_INSTR = 32'h0010_0073;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register: loads a fetched word, inserts a NOP bubble, or holds.
// Latency: 1 cycle from load/bubble request to outputs.
// Backpressure: with neither load nor bubble asserted the contents are held.
module ifid_reg
    import riscv_fetch_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            bubble_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o
);

    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_q;
    logic            valid_q;

    // Bubble wins over load; the PC field is kept on a bubble since it is only meaningful when valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (bubble_i) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_q + 32'd4;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, addresses the external ROM, fills IF/ID, halts on EBREAK.
// Latency: 1 cycle PC -> IF/ID; a redirect costs exactly one bubble.
// Backpressure: STALL freezes PC, IF/ID and counter; a redirect overrides STALL.
// Optional: FETCH_MISALIGN_TRAP_EN sends misaligned redirects to TRAP_VECTOR and pulses MISALIGN_EXC.
module fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int              POSICIONES  = 1024,
    parameter int              POS         = $clog2(POSICIONES),
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            STALL,
    input  logic            BRANCH_TAKEN,
    input  logic [XLEN-1:0] BRANCH_TARGET,
    input  logic [XLEN-1:0] INSTRUCTION,
    output logic [POS-1:0]  INSTRUCTION_ADDRESS,
    output logic [XLEN-1:0] IFID_INSTR,
    output logic [XLEN-1:0] IFID_PC,
    output logic [XLEN-1:0] IFID_PC_PLUS4,
    output logic            IFID_VALID,
    output logic            HALTED,
    output logic [XLEN-1:0] FETCH_COUNT,
    output logic            MISALIGN_EXC
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] redirect_pc;
    logic            ifid_load;
    logic            ifid_bubble;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign;
    logic exc_q;

    assign misalign    = BRANCH_TAKEN && (BRANCH_TARGET[1:0] != 2'b00);
    assign redirect_pc = misalign ? TRAP_VECTOR : BRANCH_TARGET;

    // One-cycle exception pulse following a misaligned redirect.
    always_ff @(posedge CLK) begin
        if (RST) begin
            exc_q <= 1'b0;
        end else begin
            exc_q <= misalign;
        end
    end

    assign MISALIGN_EXC = exc_q;
`else
    logic unused_trap;

    // Misaligned targets are simply rounded down to a word boundary.
    assign redirect_pc  = {BRANCH_TARGET[XLEN-1:2], 2'b00};
    assign MISALIGN_EXC = 1'b0;
    assign unused_trap  = ^{TRAP_VECTOR, BRANCH_TARGET[1:0]};
`endif

    // Next-state: redirect first, then stall hold, then normal fetch (RUN) or bubbling (HALT).
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        if (BRANCH_TAKEN) begin
            pc_d        = redirect_pc;
            ifid_bubble = 1'b1;
            state_d     = RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (!STALL) begin
                        ifid_load = 1'b1;
                        pc_d      = pc_q + 32'd4;
                        cnt_d     = cnt_q + 32'd1;
                        if (INSTRUCTION == EBREAK_INSTR) begin
                            state_d = HALT;
                        end
                    end
                end
                HALT: begin
                    if (!STALL) begin
                        ifid_bubble = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // PC, FSM state and fetch counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    ifid_reg u_ifid_reg (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (ifid_load),
        .bubble_i   (ifid_bubble),
        .instr_i    (INSTRUCTION),
        .pc_i       (pc_q),
        .instr_o    (IFID_INSTR),
        .pc_o       (IFID_PC),
        .pc_plus4_o (IFID_PC_PLUS4),
        .valid_o    (IFID_VALID)
    );

    assign INSTRUCTION_ADDRESS = pc_q[POS+1:2];
    assign HALTED              = (state_q == HALT);
    assign FETCH_COUNT         = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural combinational ROM.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: STALL and redirect-with-stall exercised by directed vectors.
module tb_fetch_unit;

    localparam int POSICIONES = 1024;
    localparam int POS        = $clog2(POSICIONES);
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic           clk;
    logic           rst;
    logic           stall;
    logic           br_taken;
    logic [31:0]    br_target;
    logic [31:0]    instr;
    logic [POS-1:0] iaddr;
    logic [31:0]    ifid_instr;
    logic [31:0]    ifid_pc;
    logic [31:0]    ifid_pc4;
    logic           ifid_valid;
    logic           halted;
    logic [31:0]    fetch_cnt;
    logic           misalign_exc;

    logic [31:0] rom [POSICIONES];
    int          n_checks;
    int          n_fails;
    int          exp_cnt;

    assign instr = rom[iaddr];

    fetch_unit dut (
        .CLK                 (clk),
        .RST                 (rst),
        .STALL               (stall),
        .BRANCH_TAKEN        (br_taken),
        .BRANCH_TARGET       (br_target),
        .INSTRUCTION         (instr),
        .INSTRUCTION_ADDRESS (iaddr),
        .IFID_INSTR          (ifid_instr),
        .IFID_PC             (ifid_pc),
        .IFID_PC_PLUS4       (ifid_pc4),
        .IFID_VALID          (ifid_valid),
        .HALTED              (halted),
        .FETCH_COUNT         (fetch_cnt),
        .MISALIGN_EXC        (misalign_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Valid fetch expected: check IF/ID contents and the bench's own running count.
    task automatic expect_fetch(input string tag, input logic [31:0] pc);
        exp_cnt++;
        check({tag, ".pc"},    ifid_pc, pc);
        check({tag, ".instr"}, ifid_instr, rom[pc[POS+1:2]]);
        check({tag, ".valid"}, {31'd0, ifid_valid}, 32'd1);
        check({tag, ".cnt"},   fetch_cnt, exp_cnt);
    endtask

    task automatic expect_bubble(input string tag);
        check({tag, ".instr"}, ifid_instr, NOP);
        check({tag, ".valid"}, {31'd0, ifid_valid}, 32'd0);
        check({tag, ".cnt"},   fetch_cnt, exp_cnt);
    endtask

    task automatic expect_reset(input string tag);
        check({tag, ".addr"},  {22'd0, iaddr}, 32'd0);
        check({tag, ".instr"}, ifid_instr, NOP);
        check({tag, ".pc"},    ifid_pc, 32'd0);
        check({tag, ".pc4"},   ifid_pc4, 32'd4);
        check({tag, ".valid"}, {31'd0, ifid_valid}, 32'd0);
        check({tag, ".halt"},  {31'd0, halted}, 32'd0);
        check({tag, ".cnt"},   fetch_cnt, 32'd0);
        check({tag, ".exc"},   {31'd0, misalign_exc}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        exp_cnt  = 0;
        for (int i = 0; i < POSICIONES; i++) rom[i] = 32'hA000_0000 + i;
        rom[4] = EBREAK;

        rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'd0;
        step(); step();
        expect_reset("rst");

        // Sequential fetch from reset.
        rst = 1'b0;
        step(); expect_fetch("seq0", 32'h0);
        check("seq0.pc4", ifid_pc4, 32'h4);
        step(); expect_fetch("seq1", 32'h4);
        check("seq1.addr", {22'd0, iaddr}, 32'd2);

        // Stall three cycles with PC at 8.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.pc",    ifid_pc, 32'h4);
            check("stall.cnt",   fetch_cnt, 32'd2);
            check("stall.addr",  {22'd0, iaddr}, 32'd2);
            check("stall.valid", {31'd0, ifid_valid}, 32'd1);
        end
        stall = 1'b0;
        step(); expect_fetch("seq2", 32'h8);
        step(); expect_fetch("seq3", 32'hC);
        check("seq.cnt4", fetch_cnt, 32'd4);

        // EBREAK at 0x10 halts.
        step(); expect_fetch("ebrk", 32'h10);
        check("ebrk.word", ifid_instr, EBREAK);
        check("ebrk.halt", {31'd0, halted}, 32'd1);
        check("ebrk.addr", {22'd0, iaddr}, 32'd5);
        for (int i = 0; i < 2; i++) begin
            step(); expect_bubble("halt");
            check("halt.halt", {31'd0, halted}, 32'd1);
            check("halt.addr", {22'd0, iaddr}, 32'd5);
        end

        // Resume from HALT with a redirect to 0.
        br_taken = 1'b1; br_target = 32'h0;
        step(); expect_bubble("resume");
        check("resume.halt", {31'd0, halted}, 32'd0);
        check("resume.addr", {22'd0, iaddr}, 32'd0);
        br_taken = 1'b0;
        step(); expect_fetch("resume0", 32'h0);
        step(); expect_fetch("resume1", 32'h4);

        // Redirect with a simultaneous stall.
        br_taken = 1'b1; br_target = 32'h40; stall = 1'b1;
        step(); expect_bubble("brst");
        check("brst.addr", {22'd0, iaddr}, 32'd16);
        br_taken = 1'b0; stall = 1'b0;
        step(); expect_fetch("brst.tgt", 32'h40);

        // Misaligned redirect target.
        br_taken = 1'b1; br_target = 32'h42;
        step(); expect_bubble("mis");
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis.addr", {22'd0, iaddr}, 32'd64);
        check("mis.exc",  {31'd0, misalign_exc}, 32'd1);
        br_taken = 1'b0;
        step(); expect_fetch("mis.tgt", 32'h100);
        check("mis.exc_off", {31'd0, misalign_exc}, 32'd0);
`else
        check("mis.addr", {22'd0, iaddr}, 32'd16);
        check("mis.exc",  {31'd0, misalign_exc}, 32'd0);
        br_taken = 1'b0;
        step(); expect_fetch("mis.tgt", 32'h40);
        check("mis.exc_off", {31'd0, misalign_exc}, 32'd0);
`endif

        // Wrap of the ROM index.
        br_taken = 1'b1; br_target = 32'hFFC;
        step(); expect_bubble("wrap.br");
        br_taken = 1'b0;
        step(); expect_fetch("wrap.last", 32'hFFC);
        check("wrap.addr", {22'd0, iaddr}, 32'd0);
        step();
        exp_cnt++;
        check("wrap.pc",    ifid_pc, 32'h1000);
        check("wrap.pc4",   ifid_pc4, 32'h1004);
        check("wrap.instr", ifid_instr, rom[0]);
        check("wrap.cnt",   fetch_cnt, exp_cnt);

        // Halt again, then reset while halted and stalled.
        br_taken = 1'b1; br_target = 32'h10;
        step(); expect_bubble("h2.br");
        br_taken = 1'b0;
        step(); expect_fetch("h2.ebrk", 32'h10);
        check("h2.halt", {31'd0, halted}, 32'd1);
        step(); expect_bubble("h2.bub");
        rst = 1'b1; stall = 1'b1;
        step(); expect_reset("rst2");
        rst = 1'b0; stall = 1'b0; exp_cnt = 0;
        step(); expect_fetch("rst2.first", 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V core: it owns the program counter, drives the word address into the combinational instruction ROM (`memoriaROM`), and latches the returned word into the IF/ID pipeline register. It handles sequential fetch, stalls, branch/jump redirects from the execute stage, and a halt on EBREAK. It sits between the instruction ROM, which is upstream, and the decode stage, which is downstream.

## Interface
- `POSICIONES`, 1024, ROM depth in 32-bit words.
- `POS`, `$clog2(POSICIONES)`, ROM address width.
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `TRAP_VECTOR`, 32'h0000_0100, redirect target for a misaligned branch (only used with the macro).

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `STALL` in 1: hold the PC, the IF/ID register and the counter.
- `BRANCH_TAKEN` in 1: redirect request from execute.
- `BRANCH_TARGET` in 32: redirect byte address.
- `INSTRUCTION` in 32: ROM data, combinational from `INSTRUCTION_ADDRESS`.
- `INSTRUCTION_ADDRESS` out POS: `PC[POS+1:2]`.
- `IFID_INSTR` out 32: latched instruction.
- `IFID_PC` out 32: PC of `IFID_INSTR`.
- `IFID_PC_PLUS4` out 32: `IFID_PC + 4`.
- `IFID_VALID` out 1: the IF/ID register holds a real instruction.
- `HALTED` out 1: the FSM is in HALT.
- `FETCH_COUNT` out 32: number of valid instructions latched.
- `MISALIGN_EXC` out 1: one-cycle exception pulse (macro only).

## Operation
- FSM states are RUN and HALT. Reset enters RUN.
- **RUN, in priority order:**
  - **`BRANCH_TAKEN`:**
    - Load PC with `BRANCH_TARGET`.
    - IF/ID becomes a bubble: `IFID_INSTR`=NOP 32'h0000_0013, `IFID_VALID`=0.
    - A redirect overrides `STALL`.
  - **`STALL`:** hold everything.
  - **Otherwise (normal fetch):**
    - IF/ID takes `INSTRUCTION` with `IFID_PC`=PC and `IFID_VALID`=1.
    - PC advances to PC+4.
    - `FETCH_COUNT` increments.
- **Entering HALT:** a normal fetch latching EBREAK (32'h0010_0073) moves the FSM to HALT. The EBREAK itself is latched valid.
- **HALT:**
  - PC holds.
  - IF/ID loads a NOP bubble on the next non-stalled edge.
  - `HALTED`=1.
  - `BRANCH_TAKEN` returns the FSM to RUN with a redirect, which squashes a wrong-path EBREAK.
  - Only reset or a redirect leaves HALT.
- **Address arithmetic:**
  - PC is 32 bits and wraps modulo 2^32.
  - The ROM index is a truncation of the PC, so it wraps modulo `POSICIONES`.
  - `PC[1:0]` is always 0.

## Timing
- **Reset values:**
  - PC=`RESET_PC`, so `INSTRUCTION_ADDRESS`=`RESET_PC[POS+1:2]`.
  - `IFID_INSTR`=NOP, `IFID_PC`=0, `IFID_PC_PLUS4`=4, `IFID_VALID`=0.
  - `HALTED`=0, `FETCH_COUNT`=0, `MISALIGN_EXC`=0.
- **Latency:** 1 cycle. The word at PC appears on the IF/ID outputs after the next rising edge.
- **First instruction:** the instruction at `RESET_PC` is valid on IF/ID one cycle after `RST` deasserts.
- **Redirect penalty:** exactly 1 bubble. The target instruction is valid 2 edges after `BRANCH_TAKEN` is sampled.
- **`STALL` held N cycles:** the outputs are frozen for N cycles with no duplicates and no losses.
- **`RST` mid-operation:** overrides everything on that edge, including in HALT and during a stall.
- **`BRANCH_TAKEN` with `STALL` on the same edge:** the redirect happens and the stall is ignored for that edge.

## Configuration
- **`FETCH_MISALIGN_TRAP_EN` defined:**
  - On `BRANCH_TAKEN` with `BRANCH_TARGET[1:0]`≠0, PC loads `TRAP_VECTOR` instead.
  - `MISALIGN_EXC` pulses high for exactly the following cycle.
  - IF/ID receives a bubble.
- **Undefined:**
  - The target's low two bits are forced to 0.
  - `MISALIGN_EXC` is tied to 0.
  - `TRAP_VECTOR` is unused.

## Structure
- **Package `riscv_fetch_pkg`:**
  - Constants NOP_INSTR (32'h0000_0013) and EBREAK_INSTR (32'h0010_0073).
  - `fetch_state_t` enum {RUN, HALT}.
  - XLEN=32.
- **Sub-module `ifid_reg`:** the IF/ID register with load, bubble and hold controls.
- **Top level:** PC, FSM and counter live in `fetch_unit`.
- **ROM:** stays external and is connected by the parent.

## Test plan
- **Reset and sequential fetch:** release reset with the ROM holding words 0..3 → IF/ID shows PC 0,4,8,12 on consecutive cycles, `FETCH_COUNT`=4, `IFID_VALID`=1 from cycle 1.
- **Stall:** assert `STALL` for 3 cycles at PC=8 → `IFID_PC` stays 4 and `FETCH_COUNT` is frozen; after release, `IFID_PC`=8 follows with no gap.
- **Redirect with simultaneous stall:** `BRANCH_TAKEN` with target 0x40 and `STALL` together → one bubble (`IFID_VALID`=0), then `IFID_PC`=0x40 valid.
- **Halt:** EBREAK at address 0x10 → EBREAK latched valid, `HALTED`=1 next cycle, PC stuck at 0x14, bubbles follow.
  - A later `BRANCH_TAKEN` to 0x0 resumes fetch.
  - `RST` asserted while halted clears all outputs to their reset values.
- **Wrap:** PC at 4*(`POSICIONES`-1) → the next `INSTRUCTION_ADDRESS` is 0 while `IFID_PC` reads 4*`POSICIONES`.
- **Misalignment, with the macro:** target 0x42 → PC=`TRAP_VECTOR`, `MISALIGN_EXC`=1 for one cycle.
- **Misalignment, without the macro:** target 0x42 → PC=0x40.
